// File: rtl/div_repeated_sub.sv
`default_nettype none
// ============================================================================
//  Module   : div_repeated_sub
//  Brief    : Unsigned W-bit divider by repeated subtraction. A controlpath
//             FSM loads dividend and divisor from a shared data_in bus, then
//             subtracts the divisor from the running remainder until it no
//             longer fits, counting the subtractions into the quotient.
//             A zero divisor is flagged on div_err instead of looping forever.
//  Options  : DIV_ITER_CNT_EN - adds the iter_cnt output (subtraction count).
//  Revision : 1.0 - initial release
// ============================================================================
module div_repeated_sub #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] data_in,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_err
`ifdef DIV_ITER_CNT_EN
    ,
    output logic [W-1:0] iter_cnt
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDA  = 3'd1;
    localparam logic [2:0] S_LDB  = 3'd2;
    localparam logic [2:0] S_CALC = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [W-1:0] c_one = W'(1);

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_q;
    logic         r_done;
    logic         r_div_err;

    // Comparator and zero detect shared by the FSM and the datapath.
    logic         w_b_zero;
    logic         w_a_ge_b;
    assign w_b_zero = (r_b == '0);
    assign w_a_ge_b = (r_a >= r_b);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; zero divisor takes priority over the compare.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_LDA;
            S_LDA:   w_next_state = S_LDB;
            S_LDB:   w_next_state = S_CALC;
            S_CALC:  if (w_b_zero || !w_a_ge_b) w_next_state = S_DONE;
            S_DONE:  if (!start) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath registers: A holds dividend then remainder, Q counts subtractions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_q       <= '0;
            r_div_err <= 1'b0;
        end else begin
            case (r_state)
                S_LDA: r_a <= data_in;
                S_LDB: begin
                    r_b       <= data_in;
                    r_q       <= '0;
                    r_div_err <= 1'b0;
                end
                S_CALC: begin
                    if (w_b_zero) begin
                        r_div_err <= 1'b1;
                    end else if (w_a_ge_b) begin
                        r_a <= r_a - r_b;
                        r_q <= r_q + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered done: high exactly while the FSM sits in S_DONE.
    always_ff @(posedge clk) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= (w_next_state == S_DONE);
    end

`ifdef DIV_ITER_CNT_EN
    logic [W-1:0] r_iter_cnt;

    // Subtraction counter, cleared with the divisor load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter_cnt <= '0;
        end else if (r_state == S_LDB) begin
            r_iter_cnt <= '0;
        end else if (r_state == S_CALC && !w_b_zero && w_a_ge_b) begin
            r_iter_cnt <= r_iter_cnt + c_one;
        end
    end

    assign iter_cnt = r_iter_cnt;
`endif

    assign done      = r_done;
    assign quotient  = r_q;
    assign remainder = r_a;
    assign div_err   = r_div_err;

endmodule
`default_nettype wire

// File: tb/tb_div_repeated_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_repeated_sub
//  Brief    : Directed self-checking bench for div_repeated_sub. Inputs change
//             on the falling edge; outputs are sampled 1 ns after the rising
//             edge. Build with DIV_ITER_CNT_EN to also check iter_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_repeated_sub;

    localparam int W      = 16;
    localparam int BUDGET = 70000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_err;
`ifdef DIV_ITER_CNT_EN
    logic [W-1:0] iter_cnt;
`endif

    int n_vec;
    int n_err;

    div_repeated_sub #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
`ifdef DIV_ITER_CNT_EN
        ,
        .iter_cnt  (iter_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one division; returns the posedge count from the first edge with
    // start=1 until done is seen high (BUDGET if it never arrives).
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int edges);
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'hBEEF;
        @(posedge clk); edges = 1;           // S_IDLE -> S_LDA
        @(negedge clk);
        data_in = a;
        @(posedge clk); edges = 2;           // dividend loaded
        @(negedge clk);
        data_in = b;
        @(posedge clk); edges = 3;           // divisor loaded
        @(negedge clk);
        data_in = 16'hDEAD;
        while (done !== 1'b1 && edges < BUDGET) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Release start after a result and let the FSM return to idle.
    task automatic release_start;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: done=%b q=%0d r=%0d err=%b, want 0 0 0 0", done, quotient, remainder, div_err);
        end
`ifdef DIV_ITER_CNT_EN
        n_vec++;
        if (iter_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_iter: iter_cnt=%0d want 0", iter_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int e;
        run_div(16'd17, 16'd5, e);
        n_vec++;
        if (e !== 7 || quotient !== 16'd3 || remainder !== 16'd2 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL div_17_5: edges=%0d q=%0d r=%0d err=%b, want 7 3 2 0", e, quotient, remainder, div_err);
        end
`ifdef DIV_ITER_CNT_EN
        n_vec++;
        if (iter_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL iter_17_5: iter_cnt=%0d want 3", iter_cnt);
        end
`endif
        release_start();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_drop_17_5: done=%b want 0", done);
        end
    endtask

    task automatic test_small;
        int e;
        run_div(16'd3, 16'd5, e);
        n_vec++;
        if (e !== 4 || quotient !== 16'd0 || remainder !== 16'd3 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL div_3_5: edges=%0d q=%0d r=%0d err=%b, want 4 0 3 0", e, quotient, remainder, div_err);
        end
        release_start();
        run_div(16'd5, 16'd5, e);
        n_vec++;
        if (e !== 5 || quotient !== 16'd1 || remainder !== 16'd0 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL div_5_5: edges=%0d q=%0d r=%0d err=%b, want 5 1 0 0", e, quotient, remainder, div_err);
        end
        release_start();
    endtask

    task automatic test_div_zero;
        int e;
        run_div(16'd17, 16'd0, e);
        n_vec++;
        if (e !== 4 || quotient !== 16'd0 || remainder !== 16'd17 || div_err !== 1'b1) begin
            n_err++;
            $display("FAIL div_17_0: edges=%0d q=%0d r=%0d err=%b, want 4 0 17 1", e, quotient, remainder, div_err);
        end
        release_start();
        run_div(16'd20, 16'd4, e);
        n_vec++;
        if (e !== 9 || quotient !== 16'd5 || remainder !== 16'd0 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL div_20_4: edges=%0d q=%0d r=%0d err=%b, want 9 5 0 0", e, quotient, remainder, div_err);
        end
        release_start();
    endtask

    task automatic test_max;
        int e;
        run_div(16'hFFFF, 16'd1, e);
        n_vec++;
        if (e !== 65539 || quotient !== 16'hFFFF || remainder !== 16'd0 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL div_65535_1: edges=%0d q=%0d r=%0d err=%b, want 65539 65535 0 0", e, quotient, remainder, div_err);
        end
`ifdef DIV_ITER_CNT_EN
        n_vec++;
        if (iter_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL iter_65535_1: iter_cnt=%0d want 65535", iter_cnt);
        end
`endif
        release_start();
    endtask

    task automatic test_reset_mid;
        int e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);                      // S_IDLE -> S_LDA
        @(negedge clk); data_in = 16'd100;
        @(posedge clk);                      // load A
        @(negedge clk); data_in = 16'd3;
        @(posedge clk);                      // load B, enter S_CALC
        repeat (5) @(posedge clk);           // five subtractions done
        @(negedge clk);
        n_vec++;
        if (quotient !== 16'd5 || remainder !== 16'd85 || done !== 1'b0) begin
            n_err++;
            $display("FAIL calc_mid_100_3: q=%0d r=%0d done=%b, want 5 85 0", quotient, remainder, done);
        end
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid: done=%b q=%0d r=%0d, want 0 0 0", done, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        run_div(16'd100, 16'd3, e);
        n_vec++;
        if (e !== 37 || quotient !== 16'd33 || remainder !== 16'd1 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL div_100_3: edges=%0d q=%0d r=%0d err=%b, want 37 33 1 0", e, quotient, remainder, div_err);
        end
        release_start();
    endtask

    task automatic test_hold_done;
        int e;
        run_div(16'd1000, 16'd7, e);
        n_vec++;
        if (e !== 146 || quotient !== 16'd142 || remainder !== 16'd6) begin
            n_err++;
            $display("FAIL div_1000_7: edges=%0d q=%0d r=%0d, want 146 142 6", e, quotient, remainder);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b1 || quotient !== 16'd142 || remainder !== 16'd6 || div_err !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: done=%b q=%0d r=%0d err=%b, want 1 142 6 0", i, done, quotient, remainder, div_err);
            end
        end
        release_start();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: done=%b want 0", done);
        end
        // A fresh operation must launch with the normal latency from idle.
        run_div(16'd9, 16'd2, e);
        n_vec++;
        if (e !== 8 || quotient !== 16'd4 || remainder !== 16'd1) begin
            n_err++;
            $display("FAIL div_9_2_after_hold: edges=%0d q=%0d r=%0d, want 8 4 1", e, quotient, remainder);
        end
        release_start();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; data_in = '0;
        test_reset();
        test_basic();
        test_small();
        test_div_zero();
        test_max();
        test_reset_mid();
        test_hold_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
